// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IR and indirect pointer, plus the FSM that picks the RAM address source.
// Optional PC_WRAP_TRAP_EN: PC saturates at its maximum and raises a sticky pc_ovf_o.
module fetch_unit #(
    parameter int unsigned   AW        = 7,
    parameter int unsigned   OPW       = 4,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int unsigned   LAST_OP   = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [OPW+AW:0]  data_i,
    input  logic             ir_en_i,
    input  logic             pc_en_i,
    input  logic             pc_load_i,
    input  logic             rdr_en_i,
    output logic [OPW-1:0]   opcode_o,
    output logic             i_flag_o,
    output logic [AW-1:0]    addr_o,
    output logic [AW-1:0]    pc_o,
    output logic [AW-1:0]    mem_addr_o,
`ifdef PC_WRAP_TRAP_EN
    output logic             pc_ovf_o,
`endif
    output logic             illegal_o
);

    localparam int unsigned DW = OPW + 1 + AW;

    typedef enum logic [1:0] {StFetch, StOperand, StIndirect} state_e;

    state_e          state_q;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   ptr_q;
    logic [DW-1:0]   ir_q;
    logic [AW-1:0]   ir_addr;
    logic            ir_iflag;
    logic [OPW-1:0]  ir_op;
    logic [AW-1:0]   addr;

    assign ir_addr  = ir_q[AW-1:0];
    assign ir_iflag = ir_q[AW];
    assign ir_op    = ir_q[DW-1 -: OPW];

    // The pointer only replaces the IR address once the FSM has actually gone indirect.
    assign addr = (ir_iflag && state_q == StIndirect) ? ptr_q : ir_addr;

    assign opcode_o  = ir_op;
    assign i_flag_o  = ir_iflag;
    assign addr_o    = addr;
    assign pc_o      = pc_q;
    assign illegal_o = {{(32-OPW){1'b0}}, ir_op} > LAST_OP;

`ifdef PC_WRAP_TRAP_EN
    logic pc_ovf_q;
    logic ovf_set;
    assign pc_ovf_o = pc_ovf_q;
`endif

    always_comb begin
        pc_d = pc_q;
`ifdef PC_WRAP_TRAP_EN
        ovf_set = 1'b0;
`endif
        if (pc_load_i) begin
            pc_d = addr;
        end else if (pc_en_i) begin
`ifdef PC_WRAP_TRAP_EN
            if (&pc_q) begin
                ovf_set = 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;
            end
`else
            pc_d = pc_q + 1'b1;
`endif
        end
    end

    always_comb begin
        case (state_q)
            StOperand:  mem_addr_o = ir_addr;
            StIndirect: mem_addr_o = ptr_q;
            default:    mem_addr_o = pc_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StFetch;
            pc_q     <= RESET_VEC;
            ptr_q    <= '0;
            ir_q     <= '0;
`ifdef PC_WRAP_TRAP_EN
            pc_ovf_q <= 1'b0;
`endif
        end else if (en_i) begin
            pc_q <= pc_d;
            if (ir_en_i) ir_q <= data_i;
            if (rdr_en_i) ptr_q <= data_i[AW-1:0];
`ifdef PC_WRAP_TRAP_EN
            if (ovf_set) pc_ovf_q <= 1'b1;
`endif
            if (pc_load_i || (pc_en_i && !ir_en_i)) begin
                state_q <= StFetch;
            end else begin
                case (state_q)
                    StFetch:    if (ir_en_i) state_q <= StOperand;
                    StOperand:  if (rdr_en_i && ir_iflag) state_q <= StIndirect;
                    StIndirect: if (ir_en_i) state_q <= StOperand;
                    default:    state_q <= StFetch;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a behavioural model pushes expected outputs per step,
// which are popped and compared one cycle later. Honours PC_WRAP_TRAP_EN when defined.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [11:0] data_i;
    logic        ir_en_i, pc_en_i, pc_load_i, rdr_en_i;
    logic [3:0]  opcode_o;
    logic        i_flag_o;
    logic [6:0]  addr_o, pc_o, mem_addr_o;
    logic        illegal_o;
`ifdef PC_WRAP_TRAP_EN
    logic        pc_ovf_o;
`endif

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .data_i     (data_i),
        .ir_en_i    (ir_en_i),
        .pc_en_i    (pc_en_i),
        .pc_load_i  (pc_load_i),
        .rdr_en_i   (rdr_en_i),
        .opcode_o   (opcode_o),
        .i_flag_o   (i_flag_o),
        .addr_o     (addr_o),
        .pc_o       (pc_o),
        .mem_addr_o (mem_addr_o),
`ifdef PC_WRAP_TRAP_EN
        .pc_ovf_o   (pc_ovf_o),
`endif
        .illegal_o  (illegal_o)
    );

    typedef struct {
        logic [3:0] op;
        logic       ifl;
        logic [6:0] addr;
        logic [6:0] pc;
        logic [6:0] mem;
        logic       ill;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state; st: 0 fetch, 1 operand, 2 indirect.
    logic [6:0]  m_pc, m_ptr;
    logic [11:0] m_ir;
    int          m_st;
    logic        m_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] m_addr();
        return (m_ir[7] && m_st == 2) ? m_ptr : m_ir[6:0];
    endfunction

    function automatic exp_t m_outputs();
        exp_t e;
        e.op   = m_ir[11:8];
        e.ifl  = m_ir[7];
        e.addr = m_addr();
        e.pc   = m_pc;
        e.mem  = (m_st == 0) ? m_pc : (m_st == 1) ? m_ir[6:0] : m_ptr;
        e.ill  = (m_ir[11:8] > 4'd12);
        e.ovf  = m_ovf;
        return e;
    endfunction

    task automatic m_reset();
        m_pc = 7'd0; m_ptr = 7'd0; m_ir = 12'd0; m_st = 0; m_ovf = 1'b0;
    endtask

    task automatic compare_outputs(input string tag, input exp_t e);
        check_val({tag, ".opcode"}, 32'(opcode_o), 32'(e.op));
        check_val({tag, ".i_flag"}, 32'(i_flag_o), 32'(e.ifl));
        check_val({tag, ".addr"}, 32'(addr_o), 32'(e.addr));
        check_val({tag, ".pc"}, 32'(pc_o), 32'(e.pc));
        check_val({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(e.mem));
        check_val({tag, ".illegal"}, 32'(illegal_o), 32'(e.ill));
`ifdef PC_WRAP_TRAP_EN
        check_val({tag, ".pc_ovf"}, 32'(pc_ovf_o), 32'(e.ovf));
`endif
    endtask

    // One clock step: drive at negedge, predict, push; compare just after the rising edge.
    task automatic step(input string tag, input logic en, input logic ie, input logic pe,
                        input logic pl, input logic re, input logic [11:0] d);
        logic [6:0]  a, npc;
        int          nst;
        exp_t        e;
        @(negedge clk_i);
        en_i = en; ir_en_i = ie; pc_en_i = pe; pc_load_i = pl; rdr_en_i = re; data_i = d;
        if (en) begin
            a   = m_addr();
            npc = m_pc;
            if (pl) npc = a;
            else if (pe) begin
`ifdef PC_WRAP_TRAP_EN
                if (m_pc == 7'd127) m_ovf = 1'b1;
                else npc = m_pc + 7'd1;
`else
                npc = m_pc + 7'd1;
`endif
            end
            nst = m_st;
            if (pl || (pe && !ie)) nst = 0;
            else if (m_st == 0 && ie) nst = 1;
            else if (m_st == 1 && re && m_ir[7]) nst = 2;
            else if (m_st == 2 && ie) nst = 1;
            m_pc = npc;
            m_st = nst;
            if (ie) m_ir = d;
            if (re) m_ptr = d[6:0];
        end
        sb.push_back(m_outputs());
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            compare_outputs(tag, e);
        end
    endtask

    initial begin
        exp_t e;
        rst_ni = 1'b0; en_i = 1'b0; data_i = '0;
        ir_en_i = 1'b0; pc_en_i = 1'b0; pc_load_i = 1'b0; rdr_en_i = 1'b0;
        m_reset();
        #12;
        e = m_outputs();
        compare_outputs("reset", e);
        rst_ni = 1'b1;

        // Bring PC to 0x25 via a load, then reset asynchronously mid-cycle.
        step("ld25_ir", 1, 1, 0, 0, 0, 12'h025);
        step("ld25_pc", 1, 0, 0, 1, 0, 12'h000);
        check_val("pre_reset.pc", 32'(pc_o), 32'h25);
        #2;
        rst_ni = 1'b0;
        #1;
        m_reset();
        e = m_outputs();
        compare_outputs("async_reset", e);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("idle0", 1, 0, 0, 0, 0, 12'h000);
        step("idle1", 1, 0, 0, 0, 0, 12'hFFF);

        // PC to 5, then the fetch cycle: IR_EN + PC_EN.
        for (int i = 0; i < 5; i++) step("inc", 1, 0, 1, 0, 0, 12'h000);
        step("fetch", 1, 1, 1, 0, 0, 12'h241);
        check_val("fetch.pc6", 32'(pc_o), 32'd6);
        check_val("fetch.mem41", 32'(mem_addr_o), 32'h41);

        // Indirect: LOAD with I=1, pointer fetched via RDR_EN.
        step("ind_ir", 1, 1, 0, 0, 0, 12'h0C3);
        step("ind_rdr", 1, 0, 0, 0, 1, 12'h010);
        check_val("ind.addr10", 32'(addr_o), 32'h10);
        check_val("ind.mem10", 32'(mem_addr_o), 32'h10);
        step("ind_exit", 1, 0, 1, 0, 0, 12'h000);

        // Branch: PC_LOAD beats PC_EN; EN=0 freezes everything.
        step("br_ir", 1, 1, 0, 0, 0, 12'h840);
        step("br_frozen", 0, 1, 1, 1, 1, 12'h555);
        step("br_take", 1, 0, 1, 1, 0, 12'h000);
        check_val("br.pc40", 32'(pc_o), 32'h40);

        // Illegal opcode boundary.
        step("ill_d", 1, 1, 0, 0, 0, 12'hD00);
        check_val("ill.d00", 32'(illegal_o), 32'd1);
        step("ill_c", 1, 1, 0, 0, 0, 12'hC00);
        check_val("ill.c00", 32'(illegal_o), 32'd0);

        // PC wrap at 127, then a load afterwards.
        step("wrap_ir", 1, 1, 0, 0, 0, 12'h07F);
        step("wrap_ld", 1, 0, 0, 1, 0, 12'h000);
        step("wrap_inc", 1, 0, 1, 0, 0, 12'h000);
`ifdef PC_WRAP_TRAP_EN
        check_val("wrap.pc_hold", 32'(pc_o), 32'd127);
        check_val("wrap.ovf", 32'(pc_ovf_o), 32'd1);
`else
        check_val("wrap.pc0", 32'(pc_o), 32'd0);
`endif
        step("wrap_reload", 1, 0, 0, 1, 0, 12'h000);

        // Random strobes and data against the model.
        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 12'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
